se_sram_srw_param: RTL
======================

// Module: se_sram_srw_param
// PURPOSE
//  Parametrised single-port synchronous SRAM: generalised width/depth, per-lane write enables,
//  selectable read latency (1 or 2), optional write-readback, optional clear-after-reset.
//  Drop-in successor to the fixed 64Kx8 single-port SRAM for CPU/peripheral memories.
//  Infers block RAM; the optional output stage is a fabric register.
// PARAMETERS
//  DATA_WIDTH      32       word width in bits; must be a multiple of LANE_WIDTH
//  LANE_WIDTH      8        bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH
//  ADDR_WIDTH      16       address width
//  DEPTH           65536    words implemented; must be <= 2**ADDR_WIDTH
//  READ_LATENCY    1        1 or 2 cycles from accepted read to data_out
//  WRITE_READBACK  0        1: an accepted write also returns the merged word as a read
//  CLEAR_ON_RESET  0        1: after reset, zero all DEPTH words before accepting requests
//  initfile        ""       RAM init file; ignored for words later cleared
// PORTS
//  sram_clock      in   1            clock; all logic on rising edge
//  reset_n         in   1            synchronous, active-low reset
//  select          in   1            request strobe
//  read_not_write  in   1            1 read, 0 write
//  write_enable    in   NUM_LANES    per-lane write enable; used only when read_not_write=0
//  address         in   ADDR_WIDTH   word address
//  write_data      in   DATA_WIDTH   write data
//  data_out        out  DATA_WIDTH   read data; holds last value between reads
//  data_out_valid  out  1            1-cycle pulse when data_out is updated
//  busy            out  1            1 while clearing; requests ignored
// BEHAVIOUR
//  Reset (reset_n=0 at edge): data_out=0, data_out_valid=0, pipeline stages emptied,
//   clear counter=0; busy=1 if CLEAR_ON_RESET else 0. RAM contents are not changed by reset itself.
//  FSM: CLEAR -> IDLE. Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
//   CLEAR: each cycle writes 0 (all lanes) to ram[counter] and increments counter;
//   the cycle counter==DEPTH-1 is written, next state IDLE, busy=0 from the following cycle.
//   Exactly DEPTH busy cycles. Reset mid-clear restarts at address 0.
//  Accept: select=1 && busy=0 at a rising edge. While busy, select is ignored: no write, no valid.
//  Write (read_not_write=0): lane i of ram[address] <= write_data lane i iff write_enable[i];
//   write_enable=0 accepted but no change. No data_out_valid unless WRITE_READBACK=1,
//   then data_out = merged post-write word, on the same timing as a read.
//  Read (read_not_write=1): write_enable ignored. Word sampled at the accept edge.
//   Latency 1: data_out/valid updated at the accept edge. Latency 2: one edge later.
//   Back-to-back reads: one result per cycle, in order.
//  Out of range (address >= DEPTH): write dropped; read still completes with data_out=0, valid=1.
//  Read-after-write to the same address on consecutive cycles returns the new data.
//  data_out is unchanged in any cycle without a valid pulse.
//  A reset during a latency-2 pipeline discards the in-flight read; no valid follows reset.
// TESTING
//  T1 default params: write 0xDEADBEEF @0x0010 we=4'hF; read 0x0010 -> next edge data_out=0xDEADBEEF, valid 1 cycle.
//  T2 lanes: init 0x11223344 @5; write 0xAABBCCDD we=4'b0101 -> read @5 gives 0x11BB33DD.
//  T3 READ_LATENCY=2: reads @1,@2,@3 back-to-back -> valid on cycles 2,3,4 after the first accept,
//     in order; data_out holds the @3 value afterward.
//  T4 CLEAR_ON_RESET=1, DEPTH=16, RAM preloaded with 0xFF: release reset -> busy for 16 cycles;
//     a write during busy is ignored; all 16 reads return 0. Reset at cycle 8 -> 16 more busy cycles.
//  T5 DEPTH=12, ADDR_WIDTH=4: write @13 is dropped; read @13 -> 0 with valid=1; @11 intact.
//  T6 WRITE_READBACK=1: write 0x5A5A5A5A we=4'hC over 0 -> data_out=0x5A5A0000 with valid, read latency.

Source files
------------

// File: rtl/se_sram_srw_param.sv
// se_sram_srw_param
//   Parametrised single-port synchronous SRAM with per-lane write enables,
//   1- or 2-cycle read latency, optional write-readback and optional
//   zero-fill after reset. Storage maps onto block RAM; the second read
//   stage (READ_LATENCY=2) is a fabric register.
//
// Ports
//   sram_clock      in   clock, rising edge
//   reset_n         in   synchronous active-low reset
//   select          in   request strobe
//   read_not_write  in   1 = read, 0 = write
//   write_enable    in   per-lane write enable (writes only)
//   address         in   word address
//   write_data      in   write data
//   data_out        out  read data, held between valid pulses
//   data_out_valid  out  one-cycle pulse when data_out updates
//   busy            out  high while the post-reset clear is running
module se_sram_srw_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 65536,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_READBACK = 0,
  parameter int CLEAR_ON_RESET = 0,
  parameter     initfile       = ""
) (
  input  logic                             sram_clock,
  input  logic                             reset_n,
  input  logic                             select,
  input  logic                             read_not_write,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] write_enable,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_out_valid,
  output logic                             busy
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   stg_data_q, stg_data_d;
  logic                    stg_valid_q, stg_valid_d;

  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    accept;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    usr_wr;
  logic                    clr_wr;
  logic                    resp;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic [DATA_WIDTH-1:0]   resp_word;

  // One extra bit so DEPTH == 2**ADDR_WIDTH compares cleanly.
  assign in_range = {1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH);
  assign idx      = address[IDX_W-1:0];

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    stg_data_d  = stg_data_q;
    stg_valid_d = 1'b0;
    clr_wr      = 1'b0;

    // reset_n gates everything that could touch the array or the outputs,
    // so asserting reset never modifies RAM contents.
    accept = reset_n && select && (state_q == ST_IDLE);
    rd_acc = accept && read_not_write;
    wr_acc = accept && !read_not_write;
    usr_wr = wr_acc && in_range;

    rd_word     = in_range ? ram[idx] : '0;
    merged_word = rd_word;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (write_enable[i]) begin
        merged_word[i*LANE_WIDTH +: LANE_WIDTH] = write_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end

    resp      = rd_acc || ((WRITE_READBACK != 0) && wr_acc);
    resp_word = read_not_write ? rd_word : (in_range ? merged_word : '0);

    if (state_q == ST_CLEAR) begin
      clr_wr    = reset_n;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_IDLE;
      end
    end

    if (READ_LATENCY == 2) begin
      stg_valid_d = resp;
      if (resp) begin
        stg_data_d = resp_word;
      end
      valid_d = stg_valid_q;
      if (stg_valid_q) begin
        data_out_d = stg_data_q;
      end
    end else begin
      valid_d = resp;
      if (resp) begin
        data_out_d = resp_word;
      end
    end
  end

  always_ff @(posedge sram_clock) begin
    if (!reset_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_q   <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      stg_data_q  <= '0;
      stg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      stg_data_q  <= stg_data_d;
      stg_valid_q <= stg_valid_d;
    end
  end

  // Single write port shared by the clear sequencer and user writes.
  always_ff @(posedge sram_clock) begin
    if (clr_wr) begin
      ram[clr_cnt_q] <= '0;
    end else if (usr_wr) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (write_enable[i]) begin
          ram[idx][i*LANE_WIDTH +: LANE_WIDTH] <= write_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign busy           = (state_q == ST_CLEAR);

endmodule
